// File: rtl/alu_mdu_pkg.sv
// alu_mdu_pkg: shared types and op encodings for the alu_mdu multiply/divide unit.
package alu_mdu_pkg;

  // Architectural op encodings seen on the op bus
  typedef enum logic [2:0] {
    MDU_MULT  = 3'b000,
    MDU_MULTU = 3'b001,
    MDU_DIV   = 3'b010,
    MDU_DIVU  = 3'b011,
    MDU_MTHI  = 3'b100,
    MDU_MTLO  = 3'b101
  } mdu_op_t;

  // Sequencer states; busy is simply "not IDLE"
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } mdu_state_t;

  localparam logic [2:0] OP_MULT  = 3'(MDU_MULT);
  localparam logic [2:0] OP_MULTU = 3'(MDU_MULTU);
  localparam logic [2:0] OP_DIV   = 3'(MDU_DIV);
  localparam logic [2:0] OP_DIVU  = 3'(MDU_DIVU);
  localparam logic [2:0] OP_MTHI  = 3'(MDU_MTHI);
  localparam logic [2:0] OP_MTLO  = 3'(MDU_MTLO);

  // Signed ops take absolute values of their operands and fix signs at the end
  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_mdu_if.sv
// alu_mdu_if: request/response bundle between the EX stage and the multiply/divide unit.
interface alu_mdu_if #(parameter int W = 32);
  logic         start;
  logic [2:0]   op;
  logic [W-1:0] srca;
  logic [W-1:0] srcb;
  logic         flush;
  logic         busy;
  logic         done;
  logic         divz;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  modport master (
    output start, op, srca, srcb, flush,
    input  busy, done, divz, hi, lo
  );

  modport slave (
    input  start, op, srca, srcb, flush,
    output busy, done, divz, hi, lo
  );
endinterface

// File: rtl/alu_mdu_divstep.sv
// alu_mdu_divstep: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder and subtracts the
// divisor when it fits, producing one quotient bit.
module alu_mdu_divstep #(parameter int W = 32) (
  input  logic [W:0]   i_rem,
  input  logic [W-1:0] i_div,
  input  logic         i_bit,
  output logic [W:0]   o_rem,
  output logic         o_qbit
);
  logic [W+1:0] w_shift;
  logic [W:0]   w_diff;

  // Trial subtraction; keep the difference only when it does not go negative
  always_comb begin
    w_shift = {i_rem, i_bit};
    w_diff  = w_shift[W:0] - {1'b0, i_div};
    if (w_shift >= {2'b00, i_div}) begin
      o_qbit = 1'b1;
      o_rem  = w_diff;
    end else begin
      o_qbit = 1'b0;
      o_rem  = w_shift[W:0];
    end
  end
endmodule

// File: rtl/alu_mdu.sv
// alu_mdu: iterative multiply/divide unit with architectural HI/LO registers.
// Signed ops run on magnitudes; sign correction is applied in the FIX state.
// Optional build macro ALU_MDU_FAST_MUL_EN: MULT/MULTU use a single-cycle
// W x W multiplier and skip the RUN state. Divide is iterative in both builds.
module alu_mdu
  import alu_mdu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic      clk,
  input  logic      rst,
  alu_mdu_if.slave  mdu
);
  localparam int CW = $clog2(W) + 1;

  mdu_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [W-1:0] r_a;          // multiplicand magnitude
  logic [W-1:0] r_b;          // divisor magnitude
  logic [W-1:0] r_q;          // multiplier bits (mul) / dividend->quotient (div)
  logic [W:0]   r_acc;        // product high half (mul) / partial remainder (div)
  logic [W-1:0] r_srca;       // original dividend, returned in HI on divide-by-zero
  logic [W-1:0] r_hi;
  logic [W-1:0] r_lo;
  logic         r_is_div;
  logic         r_neg_res;
  logic         r_neg_rem;
  logic         r_divz_pend;
  logic         r_done;
  logic         r_divz;

  logic         w_sgn_op;
  logic [W-1:0] w_abs_a;
  logic [W-1:0] w_abs_b;
  logic [W:0]   w_sum;
  logic [W:0]   w_div_rem;
  logic         w_qbit;
  logic [2*W-1:0] w_prod;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0] w_quo_fix;
  logic [W-1:0] w_rem_fix;

`ifdef ALU_MDU_FAST_MUL_EN
  logic [2*W-1:0] w_fast_prod;
  assign w_fast_prod = {{W{1'b0}}, w_abs_a} * {{W{1'b0}}, w_abs_b};
`endif

  // Operand conditioning: magnitudes for signed ops, raw values otherwise
  always_comb begin
    w_sgn_op = op_is_signed(mdu.op);
    if (w_sgn_op && mdu.srca[W-1]) begin
      w_abs_a = -mdu.srca;
    end else begin
      w_abs_a = mdu.srca;
    end
    if (w_sgn_op && mdu.srcb[W-1]) begin
      w_abs_b = -mdu.srcb;
    end else begin
      w_abs_b = mdu.srcb;
    end
  end

  // Shift-add multiply step: add multiplicand when the current multiplier bit is set
  always_comb begin
    if (r_q[0]) begin
      w_sum = {1'b0, r_acc[W-1:0]} + {1'b0, r_a};
    end else begin
      w_sum = {1'b0, r_acc[W-1:0]};
    end
  end

  alu_mdu_divstep #(.W(W)) u_divstep (
    .i_rem  (r_acc),
    .i_div  (r_b),
    .i_bit  (r_q[W-1]),
    .o_rem  (w_div_rem),
    .o_qbit (w_qbit)
  );

  // Sign fix-up of the magnitude results, consumed in FIX
  always_comb begin
    w_prod = {r_acc[W-1:0], r_q};
    if (r_neg_res) begin
      w_prod_fix = -w_prod;
      w_quo_fix  = -r_q;
    end else begin
      w_prod_fix = w_prod;
      w_quo_fix  = r_q;
    end
    if (r_neg_rem) begin
      w_rem_fix = -r_acc[W-1:0];
    end else begin
      w_rem_fix = r_acc[W-1:0];
    end
  end

  // Sequencer: accept requests in IDLE, iterate in RUN, write HI/LO in FIX
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= {CW{1'b0}};
      r_a         <= {W{1'b0}};
      r_b         <= {W{1'b0}};
      r_q         <= {W{1'b0}};
      r_acc       <= {(W+1){1'b0}};
      r_srca      <= {W{1'b0}};
      r_hi        <= {W{1'b0}};
      r_lo        <= {W{1'b0}};
      r_is_div    <= 1'b0;
      r_neg_res   <= 1'b0;
      r_neg_rem   <= 1'b0;
      r_divz_pend <= 1'b0;
      r_done      <= 1'b0;
      r_divz      <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_divz <= 1'b0;
      if (mdu.flush) begin
        // Abort wins over everything, including a same-cycle start
        r_state <= IDLE;
        r_cnt   <= {CW{1'b0}};
      end else begin
        case (r_state)
          IDLE: begin
            if (mdu.start) begin
              case (mdu.op)
                OP_MULT, OP_MULTU: begin
                  r_a         <= w_abs_a;
                  r_b         <= w_abs_b;
                  r_srca      <= mdu.srca;
                  r_is_div    <= 1'b0;
                  r_neg_res   <= w_sgn_op & (mdu.srca[W-1] ^ mdu.srcb[W-1]);
                  r_neg_rem   <= 1'b0;
                  r_divz_pend <= 1'b0;
                  r_cnt       <= {CW{1'b0}};
`ifdef ALU_MDU_FAST_MUL_EN
                  r_acc       <= {1'b0, w_fast_prod[2*W-1:W]};
                  r_q         <= w_fast_prod[W-1:0];
                  r_state     <= FIX;
`else
                  r_acc       <= {(W+1){1'b0}};
                  r_q         <= w_abs_b;
                  r_state     <= RUN;
`endif
                end
                OP_DIV, OP_DIVU: begin
                  r_a         <= w_abs_a;
                  r_b         <= w_abs_b;
                  r_q         <= w_abs_a;
                  r_acc       <= {(W+1){1'b0}};
                  r_srca      <= mdu.srca;
                  r_is_div    <= 1'b1;
                  r_neg_res   <= w_sgn_op & (mdu.srca[W-1] ^ mdu.srcb[W-1]);
                  r_neg_rem   <= w_sgn_op & mdu.srca[W-1];
                  r_divz_pend <= (mdu.srcb == {W{1'b0}});
                  r_cnt       <= {CW{1'b0}};
                  r_state     <= RUN;
                end
                OP_MTHI: r_hi <= mdu.srca;
                OP_MTLO: r_lo <= mdu.srca;
                default: ;
              endcase
            end
          end
          RUN: begin
            if (r_is_div) begin
              r_acc <= w_div_rem;
              r_q   <= {r_q[W-2:0], w_qbit};
            end else begin
              r_acc <= {1'b0, w_sum[W:1]};
              r_q   <= {w_sum[0], r_q[W-1:1]};
            end
            if (r_cnt == CW'(W - 1)) begin
              r_cnt   <= {CW{1'b0}};
              r_state <= FIX;
            end else begin
              r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            end
          end
          FIX: begin
            if (r_is_div) begin
              if (r_divz_pend) begin
                r_lo   <= {W{1'b1}};
                r_hi   <= r_srca;
                r_divz <= 1'b1;
              end else begin
                r_lo <= w_quo_fix;
                r_hi <= w_rem_fix;
              end
            end else begin
              r_hi <= w_prod_fix[2*W-1:W];
              r_lo <= w_prod_fix[W-1:0];
            end
            r_done  <= 1'b1;
            r_state <= IDLE;
          end
          default: begin
            r_state <= IDLE;
            r_cnt   <= {CW{1'b0}};
          end
        endcase
      end
    end
  end

  assign mdu.busy = (r_state != IDLE);
  assign mdu.done = r_done;
  assign mdu.divz = r_divz;
  assign mdu.hi   = r_hi;
  assign mdu.lo   = r_lo;

endmodule

// File: doc/alu_mdu.md
Name: alu_mdu

Overview:
- Parametrised multi-cycle multiply/divide unit that sits beside the combinational ALU in the EX stage.
- Supports signed and unsigned MULT/DIV, plus MTHI/MTLO writes into architectural HI/LO registers.
- Uses an iterative W-step datapath with a start/busy/done handshake, and a flush so the pipeline can abort on exceptions.

Parameters:
- W, 32, operand width; HI and LO are each W bits.
- CW, $clog2(W)+1, iteration counter width (derived; not overridden).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- start  in  1  request; sampled on a rising edge only when busy=0
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; others are no-op
- srca  in  W  multiplicand / dividend / MTHI-MTLO data
- srcb  in  W  multiplier / divisor
- flush  in  1  abort the in-flight operation
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse when HI/LO have been updated by MULT/DIV
- divz  out  1  pulses with done when the divisor was zero
- hi  out  W  HI register
- lo  out  W  LO register

Behaviour:
- Reset (async, rst=1): state=IDLE, hi=0, lo=0, busy=0, done=0, divz=0, counter=0.
- States: IDLE, RUN, FIX. busy = (state != IDLE), decoded from registered state.
- IDLE + start + MULT/DIV (edge E0):
  - Capture |srca| and |srcb|; signed ops take the absolute value, unsigned ops take the value as-is.
  - Capture result-sign and remainder-sign flags, clear the accumulator, counter=0, go to RUN.
- RUN: one shift-add (multiply) or restoring-subtract (divide) step per edge.
  - After W steps (edge E0+W), go to FIX.
- FIX (edge E0+W+1):
  - Apply sign correction and write hi/lo.
  - done=1 and divz as applicable for exactly one cycle; go to IDLE.
- Latency: done is visible W+1 edges after E0 (33 for W=32). A new start is accepted in the same cycle done is high.
- MULT/MULTU: {hi,lo} = 2W-bit product.
  - Signed product is negated in FIX iff srca and srcb signs differ.
- DIV/DIVU: lo = quotient, hi = remainder.
  - Quotient is negative iff the operand signs differ.
  - Remainder takes the dividend's sign.
  - Most-negative / -1 gives lo = most-negative, hi = 0 (wrap, no trap).
- Divide by zero, signed or unsigned:
  - Full latency still runs.
  - Result: lo = all ones, hi = srca as captured (original signed value), divz=1 with done.
- MTHI/MTLO in IDLE with start: hi (resp. lo) = srca at E0. No busy, no done.
- start while busy: ignored; operands are not re-sampled.
- flush=1 at any edge while busy:
  - state → IDLE.
  - hi/lo keep their pre-operation values; no done, no divz.
- flush and start in the same cycle: flush wins and start is dropped.
- Undefined op codes with start: no state change.
- rst asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: ALU_MDU_FAST_MUL_EN.
- Defined: MULT/MULTU skip RUN.
  - E0 captures operands and goes straight to FIX, using a single-cycle W×W multiplier.
  - done is visible 1 edge after E0; busy is high for one cycle.
- Undefined: multiply is iterative as above.
- Divide behaviour is identical in both builds.

Decomposition:
- Package alu_mdu_pkg holds:
  - mdu_op_t enum (3-bit op encodings above) and mdu_state_t enum (IDLE, RUN, FIX).
  - Localparams OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO.
- Sub-module alu_mdu_divstep: combinational restoring-divide step.
  - Inputs: partial remainder (W+1 bits), divisor, next dividend bit.
  - Outputs: new remainder and quotient bit.
- Multiply step and sign fix-up stay inline.

Test Plan:
- MULT srca=0xFFFFFFFD (-3), srcb=5 → done at E0+33: hi=0xFFFFFFFF, lo=0xFFFFFFF1; busy high for 33 cycles.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV -7 / 2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0.
- DIVU 0x12345678 / 0 → lo=0xFFFFFFFF, hi=0x12345678, divz=1 coincident with done.
- Start DIV (prior hi=0xA, lo=0xB), assert flush at RUN step 10 → busy low next cycle, no done, hi/lo still 0xA/0xB. Then issue MTLO 0x55 → lo=0x55 next edge.
- Start MULTU, then second start with different operands during RUN → ignored; result matches the first operands. Assert rst at step 5 → all outputs 0 immediately.
